// File: rtl/kx_loader_pkg.sv
// Shared types and width helpers for the {k, x} loader.
// The optional counter in axis_kx_loader is enabled by KX_LOADER_PERF_EN.
package kx_loader_pkg;

  typedef enum logic {
    LOAD_K = 1'b0,
    STREAM = 1'b1
  } kx_state_t;

  // Default geometry; the top recomputes these from its own parameters.
  localparam int R_DEF   = 8;
  localparam int C_DEF   = 8;
  localparam int W_X_DEF = 8;
  localparam int W_K_DEF = 8;

  localparam int W_KROW = C_DEF * W_K_DEF;
  localparam int W_KALL = R_DEF * C_DEF * W_K_DEF;
  localparam int W_XV   = C_DEF * W_X_DEF;
  localparam int W_KX   = W_KALL + W_XV;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_kx_loader_k_row_bank.sv
// R x W_ROW register bank holding the stationary K matrix, one write port
// addressed by row; flat read bus with row r at [r*W_ROW +: W_ROW]. No reset.
module k_row_bank #(
  parameter int R     = 8,
  parameter int W_ROW = 64,
  parameter int RW    = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [RW-1:0]        widx,
  input  logic [W_ROW-1:0]     wdata,
  output logic [R*W_ROW-1:0]   kall
);

  genvar r;
  generate
    for (r = 0; r < R; r++) begin : g_row
      logic [W_ROW-1:0] row_q;

      always_ff @(posedge clk) begin
        if (we && (widx == RW'(r))) row_q <= wdata;
      end

      assign kall[r*W_ROW +: W_ROW] = row_q;
    end
  endgenerate

endmodule

// File: rtl/axis_kx_loader.sv
// Loads K row by row, then pairs each accepted x with the held K into one
// wide {k, x} beat. Define KX_LOADER_PERF_EN to add the perf_vec_cnt output.
module axis_kx_loader
  import kx_loader_pkg::*;
#(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       s_axis_k_tready,
  input  logic                       s_axis_k_tvalid,
  input  logic [C*W_K-1:0]           s_axis_k_tdata,
  output logic                       s_axis_x_tready,
  input  logic                       s_axis_x_tvalid,
  input  logic [C*W_X-1:0]           s_axis_x_tdata,
  input  logic                       s_axis_x_tlast,
  input  logic                       m_axis_kx_tready,
  output logic                       m_axis_kx_tvalid,
  output logic [R*C*W_K+C*W_X-1:0]   m_axis_kx_tdata
`ifdef KX_LOADER_PERF_EN
  ,
  output logic [31:0]                perf_vec_cnt
`endif
);

  localparam int KROW_W = C * W_K;
  localparam int KALL_W = R * C * W_K;
  localparam int XV_W   = C * W_X;
  localparam int RCW    = cnt_w(R);

  kx_state_t          state, state_d;
  logic [RCW-1:0]     row_cnt, row_d;
  logic               vld_q;
  logic [XV_W-1:0]    x_q;
  logic [KALL_W-1:0]  k_all;
  logic               k_hs, x_hs;

  // K is frozen while any beat is pending, so k_all can feed tdata directly.
  assign s_axis_k_tready  = (state == LOAD_K) && !vld_q;
  assign s_axis_x_tready  = (state == STREAM) && (!vld_q || m_axis_kx_tready);
  assign k_hs             = s_axis_k_tvalid && s_axis_k_tready;
  assign x_hs             = s_axis_x_tvalid && s_axis_x_tready;
  assign m_axis_kx_tvalid = vld_q;
  assign m_axis_kx_tdata  = {k_all, x_q};

  always_comb begin
    state_d = state;
    row_d   = row_cnt;
    if (k_hs) begin
      if (row_cnt == RCW'(R - 1)) begin
        row_d   = '0;
        state_d = STREAM;
      end else begin
        row_d = row_cnt + RCW'(1);
      end
    end
    if (x_hs && s_axis_x_tlast) state_d = LOAD_K;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LOAD_K;
      row_cnt <= '0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_d;
      row_cnt <= row_d;
      if (x_hs)                  vld_q <= 1'b1;
      else if (m_axis_kx_tready) vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (x_hs) x_q <= s_axis_x_tdata;
  end

  k_row_bank #(
    .R     (R),
    .W_ROW (KROW_W),
    .RW    (RCW)
  ) u_bank (
    .clk   (clk),
    .we    (k_hs),
    .widx  (row_cnt),
    .wdata (s_axis_k_tdata),
    .kall  (k_all)
  );

`ifdef KX_LOADER_PERF_EN
  // Counts every x handshake; survives K reloads, only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     perf_vec_cnt <= '0;
    else if (x_hs) perf_vec_cnt <= perf_vec_cnt + 32'd1;
  end
`endif

endmodule
